// File: rtl/sd_card_arbiter_pkg.sv
// rtl/sd_card_arbiter_pkg.sv - shared types and constants for the sd_card arbiter
package sd_card_arbiter_pkg;

  localparam int SD_ADDR_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  // Round-robin pick: on a tie the port not granted last wins, else the lone requester.
  function automatic logic pick_port(input logic req0, input logic req1, input logic last_grant);
    return (req0 && req1) ? ~last_grant : req1;
  endfunction

endpackage

// File: rtl/sd_card_arbiter.sv
// rtl/sd_card_arbiter.sv - two-port round-robin byte reader in front of one sd_card page cache
module sd_card_arbiter
  import sd_card_arbiter_pkg::*;
#(
  parameter int                       SETTLE_CYCLES  = 2,
  parameter logic [SD_ADDR_WIDTH-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic [SD_ADDR_WIDTH-1:0] addr0,
  output logic                     ack0,
  input  logic                     req1,
  input  logic [SD_ADDR_WIDTH-1:0] addr1,
  output logic                     ack1,
  output logic [7:0]               rdata,
  output logic [SD_ADDR_WIDTH-1:0] sd_address,
  output logic                     sd_enable,
  input  logic [7:0]               sd_data_in,
  input  logic                     sd_busy,
  output logic                     timeout_err,
  output logic [15:0]              miss_count
);

  localparam logic [SD_ADDR_WIDTH-1:0] SETTLE_LAST  = SD_ADDR_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [SD_ADDR_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1'b1;

  arb_state_t               state_q, state_d;
  logic [SD_ADDR_WIDTH-1:0] timer_q;
  logic                     grant_q;
  logic                     last_grant_q;
  logic                     missed_q;
  logic                     pick;

  assign pick = pick_port(req0, req1, last_grant_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req0 || req1) state_d = ST_ISSUE;
      ST_ISSUE: if (timer_q == SETTLE_LAST) state_d = ST_WAIT;
      ST_WAIT:  if (!sd_busy || timer_q == TIMEOUT_LAST) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // One timer serves as settle counter in ISSUE and timeout timer in WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q      <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      missed_q     <= 1'b0;
      sd_address   <= '0;
      sd_enable    <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata        <= 8'h00;
      timeout_err  <= 1'b0;
      miss_count   <= 16'h0000;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req0 || req1) begin
            sd_address   <= pick ? addr1 : addr0;
            sd_enable    <= 1'b1;
            timer_q      <= '0;
            grant_q      <= pick;
            last_grant_q <= pick;
            missed_q     <= 1'b0;
          end
        end
        ST_ISSUE: begin
          timer_q <= (timer_q == SETTLE_LAST) ? '0 : timer_q + 1'b1;
        end
        ST_WAIT: begin
          if (!sd_busy) begin
            rdata <= sd_data_in;
            ack0  <= ~grant_q;
            ack1  <= grant_q;
          end else begin
            if (timer_q == '0) missed_q <= 1'b1;
            if (timer_q == TIMEOUT_LAST) begin
              rdata       <= 8'hFF;
              ack0        <= ~grant_q;
              ack1        <= grant_q;
              timeout_err <= 1'b1;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          sd_enable <= 1'b0;
          if (missed_q && miss_count != 16'hFFFF) miss_count <= miss_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sd_card_arbiter.md
# sd_card_arbiter

Shares one `sd_card` page-cache instance between two byte-read requesters: port 0 for CPU instruction fetch and port 1 for CPU data reads. It sequences each access through the card's enable/busy protocol and waits out page loads. It flags stalled loads with a timeout and counts page misses. It sits between the W65C832 core's memory decoder and `sd_card`, and owns `sd_card`'s `address` and `enable` inputs exclusively.

## Interface
- `SETTLE_CYCLES`, 2: cycles `sd_busy` is ignored after issue, covering the card's registered busy/data.
- `TIMEOUT_CYCLES`, 24'hFFFFFF: maximum WAIT cycles before abort (about 1.4 s at 12 MHz).
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `req0` input 1: port 0 read request; held with `addr0` until `ack0`.
- `addr0` input 24: port 0 byte address.
- `ack0` output 1: one-cycle pulse; `rdata` is valid in the same cycle.
- `req1` input 1: port 1 read request.
- `addr1` input 24: port 1 byte address.
- `ack1` output 1: one-cycle pulse for port 1.
- `rdata` output 8: returned byte, shared by both ports.
- `sd_address` output 24: drives `sd_card.address`.
- `sd_enable` output 1: drives `sd_card.enable`.
- `sd_data_in` input 8: from `sd_card.data_out`.
- `sd_busy` input 1: from `sd_card.busy`.
- `timeout_err` output 1: sticky; set on abort, cleared only by reset.
- `miss_count` output 16: saturating count of transactions that saw `sd_busy`=1 in WAIT.

## Operation
- States:
  - IDLE: no transaction in progress.
  - ISSUE: counts `SETTLE_CYCLES` edges.
  - WAIT: polls `sd_busy`.
  - DONE: the ack cycle.
- IDLE to ISSUE:
  - Taken when `req0` or `req1` is high.
  - Latches the winner's address into `sd_address`, sets `sd_enable`=1, clears the settle counter, and records `grant`.
- Arbitration is round-robin. If both requests are high, the port not granted last wins. A lone request wins immediately. `last_grant` resets to port 1, so port 0 wins the first tie.
- ISSUE: after `SETTLE_CYCLES` edges, go to WAIT. `sd_busy` is not sampled in ISSUE.
- WAIT:
  - `sd_busy`=0: `rdata`<=`sd_data_in`, pulse the granted `ack`, go to DONE.
  - `sd_busy`=1 on the first WAIT cycle: set a `missed` flag. `miss_count` increments once per transaction, at DONE, and saturates at 16'hFFFF.
  - Timer reaches `TIMEOUT_CYCLES`: `rdata`<=8'hFF, pulse `ack`, set `timeout_err`, go to DONE.
- DONE: `sd_enable`<=0, go to IDLE.
- `sd_enable` stays high throughout ISSUE and WAIT. `sd_card` freezes its page load when enable is low, so the arbiter never preempts a transaction.
- Requester rules:
  - `req`/`addr` changes before `ack` are ignored; the latched address is used.
  - `req` still high in the cycle after `ack` starts a new transaction.
- Reset, asynchronous and usable mid-operation:
  - State goes to IDLE.
  - `ack0`, `ack1`, `sd_enable`, `timeout_err`, `rdata`, `sd_address` and `miss_count` all go to 0.
  - Timer and counters are cleared.
  - Any in-flight transaction is dropped with no ack.

## Timing
- `req` sampled at edge k:
  - `sd_enable` goes high after edge k.
  - WAIT is entered at edge k+`SETTLE_CYCLES`.
  - Hit: `ack` is high in the cycle after edge k+`SETTLE_CYCLES`+1, i.e. latency `SETTLE_CYCLES`+2 cycles, 4 by default.
- Miss: latency is the hit latency plus the number of busy cycles.
- Minimum request spacing on one port is `SETTLE_CYCLES`+3 cycles, because DONE is one cycle and IDLE re-grants on the next edge.
- `ack0` and `ack1` are never high together.
- At most one `ack` per grant.

## Structure
- Shared package/include:
  - State encodings IDLE=0, ISSUE=1, WAIT=2, DONE=3.
  - `SD_ADDR_WIDTH`=24.
- No sub-module. The round-robin picker, settle counter and 24-bit timeout timer are inline.
- Only one timer register, reused: the settle counter in ISSUE and the timeout timer in WAIT.

## Test plan
- Hit on port 0: `addr0`=0x000010 with the card model reporting a hit → `ack0` 4 cycles after `req0`, `rdata` equals model byte, `miss_count`=0.
- Miss: card model holds `sd_busy` for 100 cycles → `ack0` at cycle 104, `miss_count`=1, `sd_enable` high continuously until ack.
- Contention: `req0` and `req1` raised together and both held → grants alternate 0,1,0,1, and each `ack` carries its own port's address data.
- Timeout with `TIMEOUT_CYCLES`=50: `sd_busy` stuck at 1 → `ack1` with `rdata`=0xFF, `timeout_err`=1 and sticky, next request still serviced.
- Reset mid-miss: assert `reset` low during WAIT → `sd_enable`, `ack0` and `ack1` drop immediately and no ack follows; the state after release matches the reset state.
- Saturation: preload `miss_count` to 0xFFFF via 65535 forced misses (or a bench force) → one more miss leaves it at 0xFFFF.
